divider: RTL and testbench



---
 rtl/divider.sv | 115 +++++++++++
 tb/tb_divider.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/divider.sv
// rtl/divider.sv - 32-bit radix-2 restoring divider for l.div / l.divu.
// Optional build macro: OR1300_DIVIDER_EARLY_OUT_EN (skip iterations when |A| < |B|).
module divider (
  input  logic        clock,
  input  logic        reset,
  input  logic        doDivide,
  input  logic        isSigned,
  input  logic [31:0] operantA,
  input  logic [31:0] operantB,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        divByZero
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t      state;
  logic [31:0] qReg;
  logic [31:0] remReg;
  logic [31:0] divisorMag;
  logic [4:0]  count;
  logic        negQ;
  logic        negR;

  logic [31:0] magA;
  logic [31:0] magB;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        earlyOut;

  always_comb begin
    magA    = (isSigned && operantA[31]) ? (~operantA + 32'd1) : operantA;
    magB    = (isSigned && operantB[31]) ? (~operantB + 32'd1) : operantB;
    shifted = {remReg, qReg[31]};
    // A set trial[32] means the subtraction borrowed, so the bit is restored.
    trial   = shifted - {1'b0, divisorMag};
`ifdef OR1300_DIVIDER_EARLY_OUT_EN
    earlyOut = (magA < magB);
`else
    earlyOut = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      quotient   <= 32'd0;
      remainder  <= 32'd0;
      divByZero  <= 1'b0;
      qReg       <= 32'd0;
      remReg     <= 32'd0;
      divisorMag <= 32'd0;
      count      <= 5'd0;
      negQ       <= 1'b0;
      negR       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (doDivide) begin
            busy       <= 1'b1;
            divByZero  <= 1'b0;
            negQ       <= isSigned & (operantA[31] ^ operantB[31]);
            negR       <= isSigned & operantA[31];
            qReg       <= magA;
            remReg     <= 32'd0;
            divisorMag <= magB;
            count      <= 5'd31;
            if (operantB == 32'd0) begin
              quotient  <= 32'd0;
              remainder <= operantA;
              divByZero <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else if (earlyOut) begin
              quotient  <= 32'd0;
              remainder <= operantA;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              state <= ITER;
            end
          end
        end
        ITER: begin
          if (!trial[32]) begin
            remReg <= trial[31:0];
            qReg   <= {qReg[30:0], 1'b1};
          end else begin
            remReg <= shifted[31:0];
            qReg   <= {qReg[30:0], 1'b0};
          end
          count <= count - 5'd1;
          if (count == 5'd0) state <= FIX;
        end
        FIX: begin
          quotient  <= negQ ? (~qReg + 32'd1) : qReg;
          remainder <= negR ? (~remReg + 32'd1) : remReg;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed and random checks of divider against an arithmetic model.
// Honours OR1300_DIVIDER_EARLY_OUT_EN for expected latency.
module tb_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        doDivide = 1'b0;
  logic        isSigned = 1'b0;
  logic [31:0] operantA = 32'd0;
  logic [31:0] operantB = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divByZero;

  int checks = 0;
  int failures = 0;

  divider dut (
    .clock(clock), .reset(reset), .doDivide(doDivide), .isSigned(isSigned),
    .operantA(operantA), .operantB(operantB), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .divByZero(divByZero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; truncating division gives the
  // dividend-signed remainder and wraps the 0x80000000 / -1 case naturally.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dbz, output int lat);
    longint sa, sb, ma, mb;
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (b == 32'd0) begin
      q = 32'd0; r = a; dbz = 1'b1; lat = 1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      dbz = 1'b0;
      lat = 34;
`ifdef OR1300_DIVIDER_EARLY_OUT_EN
      if (ma < mb) lat = 1;
`endif
    end
  endtask

  // Accept on E0, then sample every negedge (n = 1 is just after E0).
  task automatic runDiv(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input bit midPulse);
    logic [31:0] eq, er;
    logic        edbz;
    int          lat, doneAt, doneCount, busyBad;
    logic [31:0] gotQ, gotR;
    logic        gotZ;
    model(a, b, s, eq, er, edbz, lat);
    doneAt = -1; doneCount = 0; busyBad = 0;
    gotQ = 32'hx; gotR = 32'hx; gotZ = 1'bx;
    @(negedge clock);
    operantA = a; operantB = b; isSigned = s; doDivide = 1'b1;
    for (int n = 1; n <= lat + 3; n++) begin
      @(negedge clock);
      if (busy !== (n <= lat)) busyBad++;
      if (done === 1'b1) begin
        doneCount++;
        doneAt = n;
        gotQ = quotient; gotR = remainder; gotZ = divByZero;
      end
      doDivide = midPulse && (n == 10 || n == lat);
      operantA = $urandom; operantB = $urandom; isSigned = $urandom_range(0, 1);
    end
    doDivide = 1'b0;
    check({tag, "_latency"}, doneAt, lat);
    check({tag, "_doneCount"}, doneCount, 1);
    check({tag, "_busy"}, busyBad, 0);
    check({tag, "_quotient"}, gotQ, eq);
    check({tag, "_remainder"}, gotR, er);
    check({tag, "_divByZero"}, {31'd0, gotZ}, {31'd0, edbz});
  endtask

  initial begin
    int strayDone;
    logic [31:0] ra, rb;
    repeat (3) @(negedge clock);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_divByZero", {31'd0, divByZero}, 32'd0);
    reset = 1'b0;

    runDiv("u100_7", 32'd100, 32'd7, 1'b0, 1'b0);
    runDiv("s-100_7", 32'hFFFFFF9C, 32'd7, 1'b1, 1'b0);
    runDiv("s100_-7", 32'd100, 32'hFFFFFFF9, 1'b1, 1'b0);
    runDiv("u5_0", 32'd5, 32'd0, 1'b0, 1'b0);
    runDiv("s5_0", 32'd5, 32'd0, 1'b1, 1'b0);
    runDiv("u100_7_after_dbz", 32'd100, 32'd7, 1'b0, 1'b0);
    runDiv("s_min_-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    runDiv("u_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    runDiv("u3_10", 32'd3, 32'd10, 1'b0, 1'b0);
    runDiv("s-3_10", 32'hFFFFFFFD, 32'd10, 1'b1, 1'b0);

    // Reset in the middle of 1000 / 3.
    @(negedge clock);
    operantA = 32'd1000; operantB = 32'd3; isSigned = 1'b0; doDivide = 1'b1;
    strayDone = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clock);
      doDivide = 1'b0;
      if (done === 1'b1) strayDone++;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_quotient", quotient, 32'd0);
    check("midreset_remainder", remainder, 32'd0);
    check("midreset_divByZero", {31'd0, divByZero}, 32'd0);
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (done === 1'b1) strayDone++;
    end
    check("midreset_no_done", strayDone, 0);
    runDiv("u9_3_ignore_mid", 32'd9, 32'd3, 1'b0, 1'b1);
    runDiv("s-7_2_ignore_mid", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 20);
        2: rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 15);
      runDiv($sformatf("rand%0d", i), ra, rb, $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
